instr_loader: RTL
=================

// Module: instr_loader
// PURPOSE
//   Writes programs into instruction memory, the write-side counterpart of the CPU fetch path.
//   Receives 30-bit instruction words on a 3-wire serial link (SPI mode 0, MSB first).
//   Writes each word to consecutive instruction-memory addresses starting at 0.
//   Holds the CPU in reset while a load session is active.
// PARAMETERS
//   ADDR_W       6   instruction-memory address width (depth = 2**ADDR_W)
//   DATA_W       30  instruction word width
//   SYNC_STAGES  2   synchronizer flops on spi_sclk/spi_mosi/spi_cs_n (>=2)
// PORTS
//   clk          in   1        system clock (SB_LFOSC domain)
//   rst_n        in   1        async active-low reset
//   spi_sclk     in   1        serial clock, async; frequency <= clk/4
//   spi_mosi     in   1        serial data, sampled on synced sclk rising edge
//   spi_cs_n     in   1        session select, active low, async
//   wr_en        out  1        instruction-memory write strobe, 1-cycle pulse
//   wr_addr      out  ADDR_W   write address
//   wr_data      out  DATA_W   write data, valid while wr_en=1
//   cpu_hold     out  1        CPU reset request, active high
//   load_done    out  1        1-cycle pulse at end of a session that wrote >=1 word
//   word_count   out  ADDR_W+1 words written in current/last session
//   overflow     out  1        sticky; a word arrived after memory was full
//   parity_err   out  1        sticky; parity failure (tied 0 without macro)
// BEHAVIOUR
//   Reset: all outputs 0; FSM=IDLE; shift reg, bit counter and address cleared.
//   Inputs pass through SYNC_STAGES flops; edges detected on the last two stages.
//   FSM IDLE->SHIFT on synced cs_n falling edge: addr=0, word_count=0, overflow=0,
//     parity_err=0, cpu_hold=1 on the same cycle.
//   SHIFT: each synced sclk rising edge shifts mosi into LSB; bit_cnt++.
//     At bit_cnt==WORD_BITS, go to WRITE.
//   WRITE (1 cycle): wr_en=1, wr_data=word, wr_addr=addr; then addr++, word_count++,
//     bit_cnt=0; next state SHIFT.
//   Full: when word_count==2**ADDR_W, later complete words are not written
//     (no wr_en); overflow=1; addr does not wrap.
//   cs_n rising edge in SHIFT: discard partial word; go to DONE.
//     cs_n rising edge in WRITE: finish the write first, then go to DONE.
//   DONE (1 cycle): load_done=1 if word_count!=0; cpu_hold=0 on the next cycle; ->IDLE.
//   sclk edges while cs_n high are ignored.
//   Write latency: wr_en rises SYNC_STAGES+2 clk after the sclk edge of the last bit.
//   rst_n low mid-session: immediate return to reset state; a partial write is lost.
//   cpu_hold drops asynchronously.
// CONFIGURATION
//   INSTR_LOADER_PARITY_EN defined:
//     WORD_BITS=DATA_W+1; the final bit is even parity over the word.
//     On mismatch: no write, addr unchanged, parity_err=1 (sticky until next session).
//   Not defined: WORD_BITS=DATA_W; parity_err is constant 0.
// STRUCTURE
//   Shared package dungv_pkg:
//     typedef loader_state_t {IDLE,SHIFT,WRITE,DONE}
//     constants INSTR_W=30, IMEM_ADDR_W=6.
//   One sub-module, sync_edge_det: SYNC_STAGES synchronizer plus rise/fall pulse outputs.
//     Instantiated 3x (the mosi instance uses only its level output).
// TESTING
//   Load 3 words 0x0000_0001, 0x3FFF_FFFF, 0x1555_5555 -> wr_en x3 at addr 0,1,2;
//     exact data; word_count=3; one load_done pulse; cpu_hold 1->0.
//   cs_n rises after 17 bits of word 2 -> only word 1 written; word_count=1; load_done pulses.
//   Send 65 words -> addr 0..63 written; 65th word not written; overflow=1; word_count=64.
//   rst_n asserted at bit 20 of a word -> no wr_en; all outputs 0; next session starts at addr 0.
//   PARITY_EN: bad parity on word 2 of 3 -> words 1,3 written at addr 0,1;
//     parity_err=1; word_count=2.
//   cs_n low, 0 bits sent, cs_n high -> no wr_en; no load_done; cpu_hold pulses then 0.

Source files
------------

// File: rtl/dungv_pkg.sv
// Shared types and constants for the instruction-memory loader.
package dungv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE,
        DONE
    } loader_state_t;

    localparam int INSTR_W     = 30;
    localparam int IMEM_ADDR_W = 6;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer for an async input with rise/fall pulse outputs.
module sync_edge_det #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    // One flop past the synchronizer holds the previous level for edge detect
    logic [STAGES:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {(STAGES + 1){RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-1:0], async_i};
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~sync_q[STAGES];
    assign fall_o  = ~sync_q[STAGES-1] & sync_q[STAGES];

endmodule

// File: rtl/instr_loader.sv
// Serial (SPI mode 0, MSB first) program loader into instruction memory.
// Define INSTR_LOADER_PARITY_EN to append an even-parity bit to each word.
module instr_loader
    import dungv_pkg::*;
#(
    parameter int ADDR_W      = IMEM_ADDR_W,
    parameter int DATA_W      = INSTR_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_sclk,
    input  logic              spi_mosi,
    input  logic              spi_cs_n,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              cpu_hold,
    output logic              load_done,
    output logic [ADDR_W:0]   word_count,
    output logic              overflow,
    output logic              parity_err
);

`ifdef INSTR_LOADER_PARITY_EN
    localparam int WORD_BITS = DATA_W + 1;
`else
    localparam int WORD_BITS = DATA_W;
`endif
    localparam int CNT_W = $clog2(WORD_BITS + 1);

    logic sclk_rise;
    logic cs_lvl;
    logic cs_fall;
    logic mosi_lvl;
    logic unused_sclk_lvl;
    logic unused_sclk_fall;
    logic unused_cs_rise;
    logic unused_mosi_rise;
    logic unused_mosi_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_sclk),
        .level_o (unused_sclk_lvl),
        .rise_o  (sclk_rise),
        .fall_o  (unused_sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_mosi),
        .level_o (mosi_lvl),
        .rise_o  (unused_mosi_rise),
        .fall_o  (unused_mosi_fall)
    );

    // cs_n idles high, so its synchronizer resets high to avoid a false session
    sync_edge_det #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (spi_cs_n),
        .level_o (cs_lvl),
        .rise_o  (unused_cs_rise),
        .fall_o  (cs_fall)
    );

    loader_state_t        state_q;
    logic [WORD_BITS-1:0] shift_q;
    logic [WORD_BITS-1:0] shift_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [ADDR_W-1:0]    addr_q;
    logic [ADDR_W:0]      word_count_q;
    logic                 wr_en_q;
    logic                 cpu_hold_q;
    logic                 load_done_q;
    logic                 overflow_q;
    logic                 word_ok;
    logic                 full;

    assign shift_d = {shift_q[WORD_BITS-2:0], mosi_lvl};
    assign full    = word_count_q[ADDR_W];

`ifdef INSTR_LOADER_PARITY_EN
    logic perr_q;
    assign word_ok    = ~^shift_q;
    assign parity_err = perr_q;
`else
    assign word_ok    = 1'b1;
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            wr_en_q      <= 1'b0;
            cpu_hold_q   <= 1'b0;
            load_done_q  <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef INSTR_LOADER_PARITY_EN
            perr_q       <= 1'b0;
`endif
        end else begin
            wr_en_q     <= 1'b0;
            load_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cs_fall) begin
                        state_q      <= SHIFT;
                        shift_q      <= '0;
                        bit_cnt_q    <= '0;
                        addr_q       <= '0;
                        word_count_q <= '0;
                        overflow_q   <= 1'b0;
                        cpu_hold_q   <= 1'b1;
`ifdef INSTR_LOADER_PARITY_EN
                        perr_q       <= 1'b0;
`endif
                    end
                end
                SHIFT: begin
                    // A complete word is committed even if cs_n has risen
                    if (bit_cnt_q == CNT_W'(WORD_BITS)) begin
                        state_q <= WRITE;
                        wr_en_q <= word_ok & ~full;
                        if (word_ok && full) overflow_q <= 1'b1;
`ifdef INSTR_LOADER_PARITY_EN
                        if (!word_ok) perr_q <= 1'b1;
`endif
                    end else if (cs_lvl) begin
                        state_q     <= DONE;
                        bit_cnt_q   <= '0;
                        load_done_q <= (word_count_q != '0);
                    end else if (sclk_rise) begin
                        shift_q   <= shift_d;
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                WRITE: begin
                    bit_cnt_q <= '0;
                    if (wr_en_q) begin
                        word_count_q <= word_count_q + 1'b1;
                        if (addr_q != '1) addr_q <= addr_q + 1'b1;
                    end
                    if (cs_lvl) begin
                        state_q     <= DONE;
                        load_done_q <= (word_count_q != '0) | wr_en_q;
                    end else begin
                        state_q <= SHIFT;
                    end
                end
                DONE: begin
                    state_q    <= IDLE;
                    cpu_hold_q <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = addr_q;
    assign wr_data    = shift_q[WORD_BITS-1 -: DATA_W];
    assign cpu_hold   = cpu_hold_q;
    assign load_done  = load_done_q;
    assign word_count = word_count_q;
    assign overflow   = overflow_q;

endmodule
